shift_arbiter: RTL and testbench

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shifter_pkg.sv | 27 ++
 rtl/shift_step.sv | 25 ++
 rtl/shift_arbiter.sv | 126 ++++++++++++
 tb/tb_shift_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared types and sizing for the two-port shift arbiter.
package shifter_pkg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;
    localparam int NPORT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Two-way round-robin: on contention the port not served last wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        logic pick;
        if (req == 2'b11) begin
            pick = ~last;
        end else if (req[1]) begin
            pick = 1'b1;
        end else begin
            pick = 1'b0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational 1-bit shift/rotate step with carry-out of the bit shifted away.
module shift_step #(
    parameter int W = shifter_pkg::WIDTH
) (
    input  logic [W-1:0] value,
    input  logic         right,
    input  logic         rotate,
    output logic [W-1:0] result,
    output logic         co
);

    // Single shift in the selected direction; fill bit is the wrapped bit or zero.
    always_comb begin
        result = value;
        co     = 1'b0;
        if (right) begin
            co     = value[0];
            result = {(rotate ? value[0] : 1'b0), value[W-1:1]};
        end else begin
            co     = value[W-1];
            result = {value[W-2:0], (rotate ? value[W-1] : 1'b0)};
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter in front of a shared multi-cycle shifter: one bit per SHIFT cycle,
// result and last carry-out held until the next capture.
module shift_arbiter #(
    parameter int WIDTH = shifter_pkg::WIDTH,
    parameter int NPORT = shifter_pkg::NPORT
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NPORT-1:0]                   req,
    input  logic [NPORT*WIDTH-1:0]             din,
    input  logic [NPORT*shifter_pkg::CNT_W-1:0] cnt,
    input  logic [NPORT-1:0]                   right,
    input  logic [NPORT-1:0]                   rotate,
    output logic [NPORT-1:0]                   gnt,
    output logic                               busy,
    output logic                               done,
    output logic                               done_id,
    output logic [WIDTH-1:0]                   dout,
    output logic                               co
);

    import shifter_pkg::*;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [WIDTH-1:0]   dout_r, dout_s;
    logic               co_r, co_s;
    logic               right_r, right_s;
    logic               rot_r, rot_s;
    logic               id_r, id_s;
    logic               last_r, last_s;
    logic [NPORT-1:0]   gnt_r, gnt_s;
    logic               busy_r, done_r;
    logic               win_s;
    logic [WIDTH-1:0]   step_val_s;
    logic               step_co_s;

    // The working value lives in the result register, so dout shows progress while shifting.
    shift_step #(.W(WIDTH)) u_step (
        .value  (dout_r),
        .right  (right_r),
        .rotate (rot_r),
        .result (step_val_s),
        .co     (step_co_s)
    );

    // Next-state, capture and shift datapath.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        dout_s  = dout_r;
        co_s    = co_r;
        right_s = right_r;
        rot_s   = rot_r;
        id_s    = id_r;
        last_s  = last_r;
        gnt_s   = '0;
        win_s   = rr_pick(req, last_r);
        case (state_r)
            IDLE: begin
                if (|req) begin
                    dout_s       = win_s ? din[2*WIDTH-1:WIDTH] : din[WIDTH-1:0];
                    cnt_s        = win_s ? cnt[2*CNT_W-1:CNT_W] : cnt[CNT_W-1:0];
                    right_s      = right[win_s];
                    rot_s        = rotate[win_s];
                    co_s         = 1'b0;
                    id_s         = win_s;
                    last_s       = win_s;
                    gnt_s[win_s] = 1'b1;
                    state_s      = (cnt_s == '0) ? DONE : SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                dout_s  = step_val_s;
                co_s    = step_co_s;
                cnt_s   = cnt_r - CNT_W'(1);
                state_s = (cnt_r == CNT_W'(1)) ? DONE : SHIFT;
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            dout_r  <= '0;
            co_r    <= 1'b0;
            right_r <= 1'b0;
            rot_r   <= 1'b0;
            id_r    <= 1'b0;
            last_r  <= 1'b1;
            gnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            dout_r  <= dout_s;
            co_r    <= co_s;
            right_r <= right_s;
            rot_r   <= rot_s;
            id_r    <= id_s;
            last_r  <= last_s;
            gnt_r   <= gnt_s;
            busy_r  <= (state_s == SHIFT);
            done_r  <= (state_s == DONE);
        end
    end

    assign gnt     = gnt_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign done_id = id_r;
    assign dout    = dout_r;
    assign co      = co_r;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: hand-computed shift results, latency, arbitration and reset abort.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] din;
    logic [5:0]  cnt;
    logic [1:0]  right;
    logic [1:0]  rotate;
    logic [1:0]  gnt;
    logic        busy;
    logic        done;
    logic        done_id;
    logic [7:0]  dout;
    logic        co;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shift_arbiter #(.WIDTH(8), .NPORT(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .din     (din),
        .cnt     (cnt),
        .right   (right),
        .rotate  (rotate),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .dout    (dout),
        .co      (co)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Other port's fields get the inverse so a wrong slice select is visible.
    task automatic set_port(input int p, input logic [7:0] d, input logic [2:0] n,
                            input logic r, input logic ro);
        if (p == 0) begin
            din = {~d, d}; cnt = {~n, n}; right = {~r, r}; rotate = {~ro, ro};
        end else begin
            din = {d, ~d}; cnt = {n, ~n}; right = {r, ~r}; rotate = {ro, ~ro};
        end
    endtask

    task automatic run_op(input string tag, input int p, input logic [7:0] d, input logic [2:0] n,
                          input logic r, input logic ro, input logic [7:0] exp_dout,
                          input logic exp_co, input int exp_cyc);
        int cyc;
        @(negedge clk);
        set_port(p, d, n, r, ro);
        req = (p == 0) ? 2'b01 : 2'b10;
        @(posedge clk);
        #1 req = 2'b00;
        @(negedge clk);
        cyc = 1;
        check({tag, ".gnt"}, 32'(gnt), (p == 0) ? 32'd1 : 32'd2);
        check({tag, ".busy"}, 32'(busy), 32'(n != 3'd0));
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, ".cycle"}, 32'(cyc), 32'(exp_cyc));
        check({tag, ".dout"}, 32'(dout), 32'(exp_dout));
        check({tag, ".co"}, 32'(co), 32'(exp_co));
        check({tag, ".id"}, 32'(done_id), 32'(p));
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [1:0] seen_q[$];
        logic [1:0] prev;
        int         viol;
        int         cyc;
        int         early;
        int         dcount;
        logic [1:0] exp_order [4];

        exp_order[0] = 2'b01; exp_order[1] = 2'b10;
        exp_order[2] = 2'b01; exp_order[3] = 2'b10;

        // Reset with both ports already requesting zero-count operations.
        rst = 1'b1;
        req = 2'b11;
        din = 16'hA55A;
        cnt = 6'd0;
        right = 2'b00;
        rotate = 2'b00;
        @(negedge clk);
        check("rst.gnt", 32'(gnt), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.done_id", 32'(done_id), 32'd0);
        check("rst.dout", 32'(dout), 32'd0);
        check("rst.co", 32'(co), 32'd0);
        rst = 1'b0;

        // Continuous contention: grants alternate starting at port 0, each one cycle wide.
        prev = 2'b00;
        viol = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) seen_q.push_back(gnt);
            if (prev != 2'b00 && gnt != 2'b00) viol++;
            prev = gnt;
        end
        req = 2'b00;
        check("rr.count", 32'(seen_q.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < seen_q.size(); i++)
            check($sformatf("rr.order%0d", i), 32'(seen_q[i]), 32'(exp_order[i]));
        check("rr.single_pulse", 32'(viol), 32'd0);
        repeat (3) @(negedge clk);

        run_op("r035", 0, 8'h96, 3'd3, 1'b1, 1'b0, 8'h12, 1'b1, 4);
        run_op("r036", 1, 8'h81, 3'd1, 1'b0, 1'b1, 8'h03, 1'b1, 2);
        run_op("r037a", 0, 8'h01, 3'd7, 1'b0, 1'b0, 8'h80, 1'b0, 8);
        run_op("r037b", 0, 8'h01, 3'd0, 1'b0, 1'b0, 8'h01, 1'b0, 1);
        run_op("rotr", 1, 8'hA5, 3'd4, 1'b1, 1'b1, 8'h5A, 1'b0, 5);
        run_op("shl", 0, 8'hC3, 3'd2, 1'b0, 1'b0, 8'h0C, 1'b1, 3);

        // Request from port 0 while port 1 is shifting must wait for the done pulse.
        @(negedge clk);
        set_port(1, 8'h0F, 3'd4, 1'b0, 1'b0);
        req = 2'b10;
        @(posedge clk);
        #1 req = 2'b00;
        @(negedge clk);
        set_port(0, 8'h3C, 3'd0, 1'b0, 1'b0);
        req = 2'b01;
        cyc = 1;
        early = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (gnt[0]) early++;
            @(negedge clk);
            cyc++;
        end
        check("busy.no_grant", 32'(early + int'(gnt[0])), 32'd0);
        check("busy.cycle", 32'(cyc), 32'd5);
        check("busy.dout", 32'(dout), 32'hF0);
        @(negedge clk);
        check("busy.idle_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        check("busy.late_gnt", 32'(gnt), 32'd1);
        req = 2'b00;
        check("busy.late_done", 32'(done), 32'd1);
        check("busy.late_dout", 32'(dout), 32'h3C);

        // Reset in the second SHIFT cycle of a five-bit operation.
        @(negedge clk);
        set_port(1, 8'hF0, 3'd5, 1'b1, 1'b0);
        req = 2'b10;
        @(posedge clk);
        #1 req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort.gnt", 32'(gnt), 32'd0);
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check("abort.done_id", 32'(done_id), 32'd0);
        check("abort.dout", 32'(dout), 32'd0);
        check("abort.co", 32'(co), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("abort.no_done", 32'(dcount), 32'd0);
        din = 16'h1122;
        cnt = 6'd0;
        right = 2'b00;
        rotate = 2'b00;
        req = 2'b11;
        @(posedge clk);
        #1 req = 2'b00;
        @(negedge clk);
        check("abort.next_gnt", 32'(gnt), 32'd1);
        check("abort.next_done", 32'(done), 32'd1);
        check("abort.next_dout", 32'(dout), 32'h22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
